match_ctrl: RTL and testbench
=============================

Name: match_ctrl

Overview:
- Match sequencer for the tug-of-war playfield: gates single-pulse player presses onto the light chain and detects when a point is scored.
- Keeps per-player scores, clears the playfield between rounds and declares the match winner.
- Sits between the playerIn pulse generators and the normalLight/centerLight chain; drives the score HEX digits.

Parameters:
SERVE_CYCLES, 8, cycles in SERVE before play is enabled (board build overrides to ~25_000_000)
HOLD_CYCLES, 8, cycles the point result is held in POINT
WIN_SCORE, 7, score that ends the match; legal range 1..7

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low; 0 = reset asserted
new_game  input  1  synchronous restart request, level, active-high
l_press  input  1  left player single-cycle press pulse
r_press  input  1  right player single-cycle press pulse
edge_l  input  1  leftmost playfield light lit
edge_r  input  1  rightmost playfield light lit
l_move  output  1  registered move-left pulse to playfield L input
r_move  output  1  registered move-right pulse to playfield R input
field_clr  output  1  registered active-high playfield reset (recentres light)
l_score  output  3  left score, 0..WIN_SCORE
r_score  output  3  right score, 0..WIN_SCORE
winner  output  2  10 left, 01 right, 00 none; registered
hex_l  output  7  active-low 7-seg of l_score
hex_r  output  7  active-low 7-seg of r_score

Behaviour:
- Reset asserted (reset=0), asynchronous: state CLEAR; scores 0; winner 00; l_move, r_move 0; field_clr 1; counter 0.
- States: CLEAR, SERVE, PLAY, POINT, OVER.
- CLEAR: field_clr=1 for exactly one cycle, then SERVE with counter cleared.
- SERVE: field_clr=0, presses ignored; after SERVE_CYCLES cycles go to PLAY.
- PLAY, l_press & ~r_press & edge_l: left point. l_score+1, winner=10, no l_move, go POINT.
- PLAY, r_press & ~l_press & edge_r: right point. r_score+1, winner=01, go POINT.
- PLAY, l_press & ~r_press without edge_l: l_move=1 next cycle (latency 1, width 1).
- PLAY, r_press & ~l_press without edge_r: r_move=1 next cycle (latency 1, width 1).
- PLAY, l_press & r_press same cycle: cancel. No move, no point.
- POINT: presses ignored; hold HOLD_CYCLES cycles.
  - Then if updated score == WIN_SCORE, go OVER.
  - Otherwise clear winner to 00 and go CLEAR.
- OVER: winner and scores frozen; presses ignored; playfield not cleared.
- new_game=1 in any state: next cycle scores 0, winner 00, state CLEAR. Overrides a same-cycle point.
- Scores never exceed WIN_SCORE; counter width $clog2(max(SERVE_CYCLES,HOLD_CYCLES)+1).
- hex decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
- Reset asserted mid-round: all outputs return to reset values immediately, independent of clk.

Optional Feature:
- Macro CPU_PLAYER_EN.
- Defined:
  - 10-bit LFSR (x^10+x^7+1), seeded 10'h001 by reset, steps every cycle.
  - In PLAY the right press is internal: cpu_press = (lfsr[3:0]==4'hF); port r_press is ignored.
  - All other rules unchanged.
- Undefined: no LFSR logic; r_press used directly.

Test Plan:
- Release reset; idle 12 cycles -> field_clr high only in cycle 1; PLAY entered after 8 SERVE cycles; l_move/r_move 0 throughout.
- In PLAY, l_press pulse with edge_l=0 -> l_move=1 for one cycle, one cycle later; scores stay 0.
- In PLAY, l_press and r_press in the same cycle -> no move pulses, no score change.
- In PLAY, r_press with edge_r=1 -> r_score 0->1, winner=01 for 8 cycles, then field_clr pulse, then SERVE; hex_r=1111001.
- Left scores 7 points -> state OVER, winner=10, hex_l=1111000; further presses produce no moves; new_game=1 -> scores 0, winner 00, field_clr pulse.
- Assert reset mid-POINT, between clock edges -> scores 0, winner 00, field_clr 1 immediately; after release, normal CLEAR->SERVE sequence.

Source files
------------

// File: rtl/match_ctrl.sv
// match_ctrl: tug-of-war match sequencer (scores, rounds, winner); CPU_PLAYER_EN replaces the right player with an LFSR.
module match_ctrl #(
  parameter int SERVE_CYCLES = 8,
  parameter int HOLD_CYCLES  = 8,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       l_press,
  input  logic       r_press,
  input  logic       edge_l,
  input  logic       edge_r,
  output logic       l_move,
  output logic       r_move,
  output logic       field_clr,
  output logic [2:0] l_score,
  output logic [2:0] r_score,
  output logic [1:0] winner,
  output logic [6:0] hex_l,
  output logic [6:0] hex_r
);
  localparam int MAXC = SERVE_CYCLES > HOLD_CYCLES ? SERVE_CYCLES : HOLD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] S_END = CW'(SERVE_CYCLES - 1);
  localparam logic [CW-1:0] H_END = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0] WIN = 3'(WIN_SCORE);
  typedef enum logic [2:0] {CLEAR, SERVE, PLAY, POINT, OVER} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] l_n, r_n;
  logic [1:0] win_n;
  logic lm_n, rm_n, r_in, l_only, r_only, done;
`ifdef CPU_PLAYER_EN
  logic [9:0] lfsr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) lfsr <= 10'h001;
    else lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  assign r_in = lfsr[3:0] == 4'hF;
`else
  assign r_in = r_press;
`endif
  assign l_only = l_press & ~r_in;
  assign r_only = r_in & ~l_press;
  assign done = l_score == WIN || r_score == WIN;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    l_n = l_score;
    r_n = r_score;
    win_n = winner;
    lm_n = 1'b0;
    rm_n = 1'b0;
    if (new_game) begin
      state_n = CLEAR;
      cnt_n = '0;
      l_n = '0;
      r_n = '0;
      win_n = '0;
    end else
      case (state)
        CLEAR: begin
          state_n = SERVE;
          cnt_n = '0;
        end
        SERVE: begin
          state_n = cnt == S_END ? PLAY : SERVE;
          cnt_n = cnt == S_END ? '0 : cnt + 1'b1;
        end
        PLAY:
          if (l_only && edge_l) begin
            l_n = l_score + 3'd1;
            win_n = 2'b10;
            state_n = POINT;
            cnt_n = '0;
          end else if (r_only && edge_r) begin
            r_n = r_score + 3'd1;
            win_n = 2'b01;
            state_n = POINT;
            cnt_n = '0;
          end else begin
            lm_n = l_only;
            rm_n = r_only;
          end
        POINT: begin
          state_n = cnt == H_END ? (done ? OVER : CLEAR) : POINT;
          win_n = cnt == H_END && !done ? 2'b00 : winner;
          cnt_n = cnt == H_END ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= CLEAR;
      cnt <= '0;
      l_score <= '0;
      r_score <= '0;
      winner <= '0;
      l_move <= 1'b0;
      r_move <= 1'b0;
      field_clr <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      l_score <= l_n;
      r_score <= r_n;
      winner <= win_n;
      l_move <= lm_n;
      r_move <= rm_n;
      field_clr <= state_n == CLEAR;
    end
  function automatic logic [6:0] seg(input logic [2:0] v);
    case (v)
      3'd0: seg = 7'b1000000;
      3'd1: seg = 7'b1111001;
      3'd2: seg = 7'b0100100;
      3'd3: seg = 7'b0110000;
      3'd4: seg = 7'b0011001;
      3'd5: seg = 7'b0010010;
      3'd6: seg = 7'b0000010;
      default: seg = 7'b1111000;
    endcase
  endfunction
  assign hex_l = seg(l_score);
  assign hex_r = seg(r_score);
endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: timeline-based reference model of the match, directed scenarios then random presses.
module tb_match_ctrl;
  localparam int SERVE = 8, HOLD = 8, WIN = 7;
  logic clk = 0, reset = 0, new_game = 0, l_press = 0, r_press = 0, edge_l = 0, edge_r = 0;
  logic l_move, r_move, field_clr;
  logic [2:0] l_score, r_score;
  logic [1:0] winner;
  logic [6:0] hex_l, hex_r;
  int vectors = 0, errs = 0;
  logic [6:0] segtab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
  // Model: cycle index, cycle of last playfield clear, first cycle of current point hold (-1 = none)
  int m_cyc, m_clr, m_pt;
  bit m_over, m_lm, m_rm;
  int m_l, m_r;
  logic [1:0] m_win;

  match_ctrl #(.SERVE_CYCLES(SERVE), .HOLD_CYCLES(HOLD), .WIN_SCORE(WIN)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .l_press(l_press), .r_press(r_press),
    .edge_l(edge_l), .edge_r(edge_r), .l_move(l_move), .r_move(r_move), .field_clr(field_clr),
    .l_score(l_score), .r_score(r_score), .winner(winner), .hex_l(hex_l), .hex_r(hex_r));

  always #5 clk = ~clk;

  function automatic bit m_play();
    return !m_over && m_pt < 0 && m_cyc > m_clr + SERVE;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_clr = 0; m_pt = -1; m_over = 0; m_lm = 0; m_rm = 0;
    m_l = 0; m_r = 0; m_win = 2'b00;
  endtask

  task automatic step(input bit l, r, el, er, ng);
    m_lm = 0; m_rm = 0;
    if (ng) begin
      m_l = 0; m_r = 0; m_win = 2'b00; m_over = 0; m_pt = -1;
      m_cyc++; m_clr = m_cyc;
    end else begin
      if (m_play()) begin
        if (l && !r && el) begin m_l++; m_win = 2'b10; m_pt = m_cyc + 1; end
        else if (r && !l && er) begin m_r++; m_win = 2'b01; m_pt = m_cyc + 1; end
        else begin m_lm = l && !r; m_rm = r && !l; end
      end
      m_cyc++;
      if (m_pt >= 0 && m_cyc == m_pt + HOLD) begin
        m_pt = -1;
        if (m_l == WIN || m_r == WIN) m_over = 1;
        else begin m_win = 2'b00; m_clr = m_cyc; end
      end
    end
  endtask

  task automatic chk(input string n, input logic [6:0] a, input logic [6:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask

  task automatic compare_all();
    chk("l_move", 7'(l_move), 7'(m_lm));
    chk("r_move", 7'(r_move), 7'(m_rm));
    chk("field_clr", 7'(field_clr), 7'(m_cyc == m_clr));
    chk("l_score", 7'(l_score), 7'(m_l));
    chk("r_score", 7'(r_score), 7'(m_r));
    chk("winner", 7'(winner), 7'(m_win));
    chk("hex_l", hex_l, segtab[m_l]);
    chk("hex_r", hex_r, segtab[m_r]);
  endtask

  task automatic tick(input bit l, r, el, er, ng);
    l_press = l; r_press = r; edge_l = el; edge_r = er; new_game = ng;
    @(posedge clk);
    step(l, r, el, er, ng);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_play();
    for (int i = 0; i < 40 && !m_play(); i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_fc_lit", 7'(field_clr), 7'd1);
    chk("rst_hex_lit", hex_l, 7'b1000000);
    reset = 1;
    repeat (12) tick(0, 0, 0, 0, 0);
    chk("serve_done_fc_lit", 7'(field_clr), 7'd0);
    tick(1, 0, 0, 0, 0);
    chk("lmove_lit", 7'(l_move), 7'd1);
    tick(0, 0, 0, 0, 0);
    chk("lmove_width_lit", 7'(l_move), 7'd0);
    tick(1, 1, 0, 0, 0);
    chk("cancel_lit", 7'({l_move, r_move}), 7'd0);
    tick(0, 1, 0, 1, 0);
    chk("rpoint_score_lit", 7'(r_score), 7'd1);
    chk("rpoint_win_lit", 7'(winner), 7'b01);
    chk("rpoint_hex_lit", hex_r, 7'b1111001);
    repeat (8) tick(0, 0, 0, 0, 0);
    chk("hold_end_fc_lit", 7'(field_clr), 7'd1);
    chk("hold_end_win_lit", 7'(winner), 7'b00);
    for (int k = 0; k < 7; k++) begin
      wait_play();
      tick(1, 0, 1, 0, 0);
    end
    repeat (9) tick(0, 0, 0, 0, 0);
    chk("over_win_lit", 7'(winner), 7'b10);
    chk("over_hex_lit", hex_l, 7'b1111000);
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("over_nomove_lit", 7'({l_move, r_move}), 7'd0);
    tick(0, 0, 0, 0, 1);
    chk("ng_score_lit", 7'({l_score, r_score}), 7'd0);
    chk("ng_fc_lit", 7'(field_clr), 7'd1);
    wait_play();
    tick(1, 0, 1, 0, 0);
    repeat (3) tick(0, 0, 0, 0, 0);
    #2 reset = 0;
    #1;
    chk("async_fc_lit", 7'(field_clr), 7'd1);
    chk("async_score_lit", 7'({l_score, r_score}), 7'd0);
    chk("async_win_lit", 7'(winner), 7'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 1;
    repeat (12) tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 299) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
